tlb_lookup: RTL

//  Fully associative data TLB sitting between address generation (linear address out of
//  the 32-bit CLA adder) and the cache tag stage. Translates 32-bit linear to 32-bit

---
 rtl/tlb_lookup_if.sv | 33 +++
 rtl/tlb_lookup.sv | 129 ++++++++++++
 2 files changed

// File: rtl/tlb_lookup_if.sv
// Lookup, response, fill and flush signals of the data TLB.
// master = address-generation / page-walker side, slave = the TLB.
interface tlb_lookup_if #(
    parameter int VPN_W = 20,
    parameter int PPN_W = 20
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_vaddr;
    logic             req_write;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_paddr;
    logic             resp_hit;
    logic             resp_fault;
    logic             fill_valid;
    logic [VPN_W-1:0] fill_vpn;
    logic [PPN_W-1:0] fill_ppn;
    logic             fill_writable;
    logic             flush;

    modport master (
        output req_valid, req_vaddr, req_write, resp_ready,
        output fill_valid, fill_vpn, fill_ppn, fill_writable, flush,
        input  req_ready, resp_valid, resp_paddr, resp_hit, resp_fault
    );

    modport slave (
        input  req_valid, req_vaddr, req_write, resp_ready,
        input  fill_valid, fill_vpn, fill_ppn, fill_writable, flush,
        output req_ready, resp_valid, resp_paddr, resp_hit, resp_fault
    );
endinterface

// File: rtl/tlb_lookup.sv
// Fully associative data TLB, 4 KB pages, one-cycle registered lookup.
// Round-robin refill through the fill port, flush invalidates everything.
module tlb_lookup #(
    parameter int ENTRIES = 8,
    parameter int VPN_W   = 20,
    parameter int PPN_W   = 20
) (
    input  logic         clk,
    input  logic         rst,
    tlb_lookup_if.slave  bus
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] wr_q;
    logic [VPN_W-1:0]   vpn_q [ENTRIES];
    logic [PPN_W-1:0]   ppn_q [ENTRIES];
    logic [IDX_W-1:0]   ptr_q;

    logic [VPN_W-1:0]   req_vpn;
    logic [ENTRIES-1:0] lk_hit;
    logic [ENTRIES-1:0] fl_hit;
    logic [ENTRIES-1:0] fill_we;
    logic [PPN_W-1:0]   lk_ppn;
    logic               lk_wr;
    logic               lk_any;
    logic               accept;
    logic               fill_en;
    logic               fill_new;

    logic               resp_valid_q;
    logic               resp_hit_q;
    logic               resp_fault_q;
    logic [31:0]        resp_paddr_q;

    assign req_vpn  = bus.req_vaddr[31 -: VPN_W];
    assign lk_any   = |lk_hit;
    assign fill_en  = bus.fill_valid & ~bus.flush;
    assign fill_new = fill_en & ~(|fl_hit);

    // No skid buffer: a new request fits only if the response slot frees
    assign bus.req_ready = ~resp_valid_q | bus.resp_ready;
    assign accept        = bus.req_valid & bus.req_ready;

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_paddr = resp_paddr_q;

    // Parallel tag compare for the lookup and for the fill port
    always_comb begin
        lk_hit = '0;
        fl_hit = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            lk_hit[i] = valid_q[i] && (vpn_q[i] == req_vpn);
            fl_hit[i] = valid_q[i] && (vpn_q[i] == bus.fill_vpn);
        end
    end

    // At most one entry matches, so an OR of the gated entries selects it
    always_comb begin
        lk_ppn = '0;
        lk_wr  = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lk_hit[i]) begin
                lk_ppn = lk_ppn | ppn_q[i];
                lk_wr  = lk_wr | wr_q[i];
            end
        end
    end

    // Fill rewrites a matching entry in place, else the round-robin victim
    always_comb begin
        fill_we = '0;
        if (fill_en) begin
            if (|fl_hit) begin
                fill_we = fl_hit;
            end else begin
                fill_we[ptr_q] = 1'b1;
            end
        end
    end

    // Tag and data arrays; contents are qualified by valid_q, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (fill_we[i]) begin
                vpn_q[i] <= bus.fill_vpn;
                ppn_q[i] <= bus.fill_ppn;
                wr_q[i]  <= bus.fill_writable;
            end
        end
    end

    // Valid bits and replacement pointer; flush beats a same-cycle fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (fill_en) begin
            valid_q <= valid_q | fill_we;
            if (fill_new) begin
                ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + IDX_W'(1);
            end
        end
    end

    // Response register: loads on accept, holds until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_paddr_q <= '0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= lk_any;
            resp_fault_q <= lk_any & bus.req_write & ~lk_wr;
            resp_paddr_q <= lk_any ? 32'({lk_ppn, bus.req_vaddr[11:0]})
                                   : 32'd0;
        end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end
endmodule
